// File: rtl/mem_port_arbiter.sv
// Arbitrates the single byte-RAM port between instruction fetch and data access, with ack/err and a completion timeout.
// Optional alignment rejection is enabled by defining MEM_ARB_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              ifReq,
  input  logic [ADDR_W-1:0] ifAddr,
  output logic              ifAck,
  output logic              ifErr,
  output logic [DATA_W-1:0] ifData,
  input  logic              dReq,
  input  logic              dRW,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [1:0]        dSize,
  input  logic [DATA_W-1:0] dWData,
  output logic              dAck,
  output logic              dErr,
  output logic [DATA_W-1:0] dRData,
  output logic              busy,
  output logic              memFuncActive,
  output logic              readWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  output logic [1:0]        dataSize,
  input  logic              memFuncComplete,
  input  logic [DATA_W-1:0] dataOut
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, REJ} state_t;

  state_t            state;
  state_t            nextState;
  logic              ownerData;
  logic              rwQ;
  logic              errQ;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic [DATA_W-1:0] wdataQ;
  logic [CNT_W-1:0]  cnt;

  logic              grantReq;
  logic [ADDR_W-1:0] selAddr;
  logic [1:0]        selSize;
  logic              misaligned;
  logic              reject;
  logic              timedOut;
  logic              waitDone;

  // Data port wins over fetch; fetch is always a word read.
  always_comb begin
    grantReq = dReq | ifReq;
    selAddr  = dReq ? dAddr : ifAddr;
    selSize  = dReq ? dSize : 2'b11;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    misaligned = ((selSize == 2'b11) && (selAddr[1:0] != 2'b00)) ||
                 ((selSize == 2'b01) && selAddr[0]);
`else
    misaligned = 1'b0;
`endif
    reject   = (selSize == 2'b10) || misaligned;
    timedOut = !memFuncComplete && (cnt == CNT_LAST);
    waitDone = memFuncComplete || timedOut;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (grantReq) nextState = reject ? REJ : ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (waitDone) nextState = RESP;
      RESP:    nextState = IDLE;
      REJ:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= nextState;
  end

  // memFuncComplete is only looked at in WAIT, so a stale level left over in ISSUE is ignored.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      ownerData <= 1'b0;
      rwQ       <= 1'b0;
      errQ      <= 1'b0;
      addrQ     <= '0;
      sizeQ     <= '0;
      wdataQ    <= '0;
      cnt       <= '0;
      ifData    <= '0;
      dRData    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantReq) begin
            ownerData <= dReq;
            rwQ       <= dReq & dRW;
            addrQ     <= selAddr;
            sizeQ     <= selSize;
            wdataQ    <= dReq ? dWData : '0;
            errQ      <= reject;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (waitDone) begin
            errQ <= timedOut;
            if (ownerData) dRData <= timedOut ? '0 : dataOut;
            else           ifData <= timedOut ? '0 : dataOut;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  logic ackPhase;
  assign ackPhase      = (state == RESP) || (state == REJ);
  assign ifAck         = ackPhase && !ownerData;
  assign ifErr         = ifAck && errQ;
  assign dAck          = ackPhase && ownerData;
  assign dErr          = dAck && errQ;
  assign busy          = (state != IDLE);
  assign memFuncActive = (state == ISSUE) || (state == WAIT);
  assign readWrite     = rwQ;
  assign address       = addrQ;
  assign dataIn        = wdataQ;
  assign dataSize      = sizeQ;

endmodule
